sumsq_acc: RTL and testbench

Streaming sum-of-squares accumulator that sits directly upstream of the combinational integer square-root stage. It accepts signed samples over a valid/ready stream and accumulates their squares into a `LEN`-bit unsigned sum, one sum per `in_last`-delimited packet. It then presents that sum with a valid/ready handshake as the square-root stage's `LEN`-bit radicand. Square root of the result yields the packet's vector magnitude (L2 norm).

---
 rtl/sumsq_pkg.sv | 15 +
 rtl/sumsq_acc_sq.sv | 22 ++
 rtl/sumsq_acc.sv | 126 ++++++++++++
 tb/tb_sumsq_acc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sumsq_pkg.sv
// Shared definitions for the sum-of-squares accumulator: FSM state encoding and
// the derivation of the sample width from the sum width.
package sumsq_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } sumsq_state_e;

  // The sample is half the radicand width so its square always fits.
  function automatic int dlen_of(input int len);
    return len / 2;
  endfunction

endpackage

// File: rtl/sumsq_acc_sq.sv
// Combinational square of a signed sample: magnitude first, then an unsigned
// multiply into the full sum width.
module sumsq_sq
  import sumsq_pkg::*;
#(
  parameter int LEN = 16
) (
  input  logic signed [dlen_of(LEN)-1:0] data_i,
  output logic        [LEN-1:0]          sq_o
);

  localparam int DLEN = dlen_of(LEN);

  logic [DLEN-1:0] mag;
  logic [LEN-1:0]  mag_w;

  // The most negative sample negates to itself, which as unsigned is 2^(DLEN-1).
  assign mag   = data_i[DLEN-1] ? $unsigned(-data_i) : $unsigned(data_i);
  assign mag_w = {{(LEN-DLEN){1'b0}}, mag};
  assign sq_o  = mag_w * mag_w;

endmodule

// File: rtl/sumsq_acc.sv
// Streaming sum-of-squares accumulator feeding the integer square-root stage.
// Define SUMSQ_SAT_EN for a saturating sum with overflow reporting; otherwise the sum wraps.
module sumsq_acc
  import sumsq_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [dlen_of(LEN)-1:0] in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic        [LEN-1:0]         out_sum,
  output logic        [CNT_W-1:0]       out_count,
  output logic                          out_ovf
);

  sumsq_state_e     state_q, state_d;
  logic [LEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [LEN-1:0]   sq;
  logic [LEN-1:0]   sum_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             accept;

  sumsq_sq #(.LEN(LEN)) u_sq (
    .data_i (in_data),
    .sq_o   (sq)
  );

  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign cnt_next  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef SUMSQ_SAT_EN
  logic             ovf_q, ovf_d;
  logic             out_ovf_q, out_ovf_d;
  logic [LEN:0]     sum_full;

  // Carry out of the top bit clamps the sum and marks the packet as overflowed.
  assign sum_full = {1'b0, acc_q} + {1'b0, sq};
  assign sum_next = sum_full[LEN] ? '1 : sum_full[LEN-1:0];
  assign ovf_next = ovf_q | sum_full[LEN];
  assign out_ovf  = out_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  always_comb begin
    ovf_d     = ovf_q;
    out_ovf_d = out_ovf_q;
    if (accept) begin
      if (in_last) begin
        ovf_d     = 1'b0;
        out_ovf_d = ovf_next;
      end else begin
        ovf_d     = ovf_next;
      end
    end
  end
`else
  assign sum_next = acc_q + sq;
  assign ovf_next = 1'b0;
  assign out_ovf  = ovf_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

  // A last beat always (re)loads the result, even while one is being drained.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    if (state_q == ST_HOLD && out_ready) begin
      state_d = ST_ACCUM;
    end
    if (accept) begin
      if (in_last) begin
        out_sum_d   = sum_next;
        out_count_d = cnt_next;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = ST_HOLD;
      end else begin
        acc_d = sum_next;
        cnt_d = cnt_next;
      end
    end
  end

  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_sumsq_acc.sv
// Directed bench for sumsq_acc at LEN=16; overflow expectations follow SUMSQ_SAT_EN.
module tb_sumsq_acc;

  localparam int LEN   = 16;
  localparam int DLEN  = 8;
  localparam int CNT_W = 8;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DLEN-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LEN-1:0]         out_sum;
  logic [CNT_W-1:0]       out_count;
  logic                   out_ovf;

  int n_cmp;
  int n_bad;

  sumsq_acc #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [DLEN-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      in_data  = DLEN'($urandom);
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_sum !== 16'd0) begin n_bad++; $display("FAIL rst_sum got %0d want 0", out_sum); end
    n_cmp++; if (out_count !== 8'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", out_count); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %0b want 0", out_ovf); end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    rst_n    = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_ignore();
    in_valid = 1'b0;
    in_last  = 1'b1;
    in_data  = 8'sd9;
    tick();
    in_last = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ignore_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(8'sd3, 1'b0);
    beat(-8'sd4, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_sum !== 16'd25) begin n_bad++; $display("FAIL basic_sum got %0d want 25", out_sum); end
    n_cmp++; if (out_count !== 8'd2) begin n_bad++; $display("FAIL basic_count got %0d want 2", out_count); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %0b want 0", out_ovf); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(8'sd3, 1'b0);
    beat(-8'sd4, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'sd7;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got %0b want 0", i, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sum !== 16'd25 || out_count !== 8'd2) begin
        n_bad++; $display("FAIL bp_hold[%0d] got v=%0b s=%0d c=%0d want v=1 s=25 c=2", i, out_valid, out_sum, out_count);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drop got %0b want 0", out_valid); end
    beat(8'sd1, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 16'd50 || out_count !== 8'd2) begin
      n_bad++; $display("FAIL bp_next got v=%0b s=%0d c=%0d want v=1 s=50 c=2", out_valid, out_sum, out_count);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [LEN-1:0] exp_sum;
    logic           exp_ovf;
`ifdef SUMSQ_SAT_EN
    exp_sum = 16'd65535;
    exp_ovf = 1'b1;
`else
    exp_sum = 16'd16384;
    exp_ovf = 1'b0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(8'sh80, (i == 4));
    n_cmp++; if (out_sum !== exp_sum) begin n_bad++; $display("FAIL ovf_sum got %0d want %0d", out_sum, exp_sum); end
    n_cmp++; if (out_ovf !== exp_ovf) begin n_bad++; $display("FAIL ovf_flag got %0b want %0b", out_ovf, exp_ovf); end
    n_cmp++; if (out_count !== 8'd5) begin n_bad++; $display("FAIL ovf_count got %0d want 5", out_count); end
    tick();
    beat(8'sd2, 1'b1);
    n_cmp++; if (out_sum !== 16'd4 || out_ovf !== 1'b0) begin
      n_bad++; $display("FAIL ovf_clear got s=%0d o=%0b want s=4 o=0", out_sum, out_ovf);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    beat(8'sd10, 1'b0);
    beat(8'sd10, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    beat(8'sd5, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_sum !== 16'd25 || out_count !== 8'd1) begin
      n_bad++; $display("FAIL rstmid got v=%0b s=%0d c=%0d want v=1 s=25 c=1", out_valid, out_sum, out_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      in_data = DLEN'(v);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %0b want 1", v, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sum !== 16'(v * v) || out_count !== 8'd1) begin
        n_bad++; $display("FAIL b2b_sum[%0d] got v=%0b s=%0d c=%0d want v=1 s=%0d c=1", v, out_valid, out_sum, out_count, v * v);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop got %0b want 0", out_valid); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_ignore();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
